// File: rtl/debug_controller.sv
// UART-side debug unit: loads instruction memory, runs or single-steps the pipeline, and dumps PC/cycles/registers over tx.
// Optional data-memory dump is enabled with DEBUG_DMEM_DUMP_EN.
module debug_controller #(
  parameter int NB_DATA    = 32,
  parameter int N_BYTES    = 4,
  parameter int N_BITS     = 8,
  parameter int NB_ADDR    = 7,
  parameter int NB_PC      = 7,
  parameter int NB_REG     = 5,
  parameter int N_REGISTER = 32,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
`ifdef DEBUG_DMEM_DUMP_EN
  ,
  parameter int N_DMEM_WORDS = 32
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_BITS-1:0]  rx_data_i,
  input  logic               rx_done_i,
  output logic [N_BITS-1:0]  tx_data_o,
  output logic               tx_start_o,
  input  logic               tx_done_i,
  output logic               imem_wr_en_o,
  output logic [NB_ADDR-1:0] imem_addr_o,
  output logic [NB_DATA-1:0] imem_data_o,
  output logic               en_pipeline_o,
  input  logic               halt_i,
  input  logic [NB_PC-1:0]   pc_i,
  output logic [NB_REG-1:0]  reg_addr_o,
  input  logic [NB_DATA-1:0] reg_data_i,
`ifdef DEBUG_DMEM_DUMP_EN
  output logic [NB_ADDR-1:0] dmem_addr_o,
  input  logic [NB_DATA-1:0] dmem_data_i,
`endif
  output logic               load_err_o
);

`ifdef DEBUG_DMEM_DUMP_EN
  localparam int N_WORDS = 2 + N_REGISTER + N_DMEM_WORDS;
`else
  localparam int N_WORDS = 2 + N_REGISTER;
`endif
  localparam int NB_WIDX = $clog2(N_WORDS + 1);
  localparam int NB_BCNT = $clog2(N_BYTES + 1);

  localparam logic [N_BITS-1:0] CMD_LOAD = N_BITS'(8'h4C);
  localparam logic [N_BITS-1:0] CMD_CONT = N_BITS'(8'h43);
  localparam logic [N_BITS-1:0] CMD_STEP = N_BITS'(8'h53);
  localparam logic [N_BITS-1:0] CMD_NEXT = N_BITS'(8'h4E);
  localparam logic [N_BITS-1:0] CMD_QUIT = N_BITS'(8'h51);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_LOAD_WR, S_RUN, S_STEP_WAIT, S_STEP, S_STEP_POST,
    S_DUMP_ADDR, S_DUMP_CAP, S_DUMP_SEND, S_DUMP_WAIT
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  state_t               r_ret;
  logic                 r_step_halt;
  logic [NB_DATA-1:0]   r_word;
  logic [NB_BCNT-1:0]   r_byte_cnt;
  logic [NB_ADDR-1:0]   r_addr;
  logic                 r_load_err;
  logic [NB_DATA-1:0]   r_cycle;
  logic [NB_WIDX-1:0]   r_widx;
  logic [NB_DATA-1:0]   r_shift;
  logic [NB_REG-1:0]    r_reg_addr;
`ifdef DEBUG_DMEM_DUMP_EN
  logic [NB_ADDR-1:0]   r_dmem_addr;
  logic                 w_dmem_sel;
`endif

  logic                 w_en;
  logic                 w_tx_start;
  logic                 w_imem_wr;
  logic                 w_byte_last;
  logic                 w_word_last;
  logic                 w_is_halt;
  logic                 w_addr_last;
  logic                 w_reg_sel;
  logic [NB_DATA-1:0]   w_word_src;

  assign w_byte_last = (r_byte_cnt == NB_BCNT'(N_BYTES - 1));
  assign w_word_last = (r_widx == NB_WIDX'(N_WORDS - 1));
  assign w_is_halt   = (r_word == HALT_WORD);
  assign w_addr_last = &r_addr;
  assign w_reg_sel   = (r_widx >= NB_WIDX'(2)) && (r_widx < NB_WIDX'(2 + N_REGISTER));
`ifdef DEBUG_DMEM_DUMP_EN
  assign w_dmem_sel  = (r_widx >= NB_WIDX'(2 + N_REGISTER));
`endif

  // Source of the word being dumped, indexed by word position in the dump
  always_comb begin
    w_word_src = reg_data_i;
    if (r_widx == '0) begin
      w_word_src = NB_DATA'(pc_i);
    end else if (r_widx == NB_WIDX'(1)) begin
      w_word_src = r_cycle;
    end
`ifdef DEBUG_DMEM_DUMP_EN
    else if (w_dmem_sel) begin
      w_word_src = dmem_data_i;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_en         = 1'b0;
    w_tx_start   = 1'b0;
    w_imem_wr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_done_i) begin
          if (rx_data_i == CMD_LOAD)      w_state_next = S_LOAD;
          else if (rx_data_i == CMD_CONT) w_state_next = S_RUN;
          else if (rx_data_i == CMD_STEP) w_state_next = S_STEP_WAIT;
        end
      end
      S_LOAD: begin
        if (rx_done_i && w_byte_last) w_state_next = S_LOAD_WR;
      end
      S_LOAD_WR: begin
        w_imem_wr    = 1'b1;
        w_state_next = (w_is_halt || w_addr_last) ? S_IDLE : S_LOAD;
      end
      S_RUN: begin
        w_en = 1'b1;
        if (halt_i) w_state_next = S_DUMP_ADDR;
      end
      S_STEP_WAIT: begin
        if (rx_done_i) begin
          if (rx_data_i == CMD_NEXT)      w_state_next = S_STEP;
          else if (rx_data_i == CMD_QUIT) w_state_next = S_IDLE;
        end
      end
      S_STEP: begin
        w_en         = 1'b1;
        w_state_next = S_STEP_POST;
      end
      S_STEP_POST: w_state_next = S_DUMP_ADDR;
      S_DUMP_ADDR: w_state_next = S_DUMP_CAP;
      S_DUMP_CAP:  w_state_next = S_DUMP_SEND;
      S_DUMP_SEND: begin
        w_tx_start   = 1'b1;
        w_state_next = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        if (tx_done_i) begin
          if (!w_byte_last)      w_state_next = S_DUMP_SEND;
          else if (w_word_last)  w_state_next = r_ret;
          else                   w_state_next = S_DUMP_ADDR;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ret       <= S_IDLE;
      r_step_halt <= 1'b0;
      r_word      <= '0;
      r_byte_cnt  <= '0;
      r_addr      <= '0;
      r_load_err  <= 1'b0;
      r_cycle     <= '0;
      r_widx      <= '0;
      r_shift     <= '0;
      r_reg_addr  <= '0;
`ifdef DEBUG_DMEM_DUMP_EN
      r_dmem_addr <= '0;
`endif
    end else begin
      if (w_en) r_cycle <= r_cycle + NB_DATA'(1);
      case (r_state)
        S_IDLE: begin
          if (w_state_next == S_LOAD) begin
            r_addr     <= '0;
            r_load_err <= 1'b0;
            r_byte_cnt <= '0;
          end else if (w_state_next == S_RUN || w_state_next == S_STEP_WAIT) begin
            r_cycle <= '0;
          end
        end
        S_LOAD: begin
          if (rx_done_i) begin
            r_word     <= {rx_data_i, r_word[NB_DATA-1:N_BITS]};
            r_byte_cnt <= w_byte_last ? '0 : r_byte_cnt + NB_BCNT'(1);
          end
        end
        S_LOAD_WR: begin
          r_addr <= r_addr + NB_ADDR'(1);
          if (!w_is_halt && w_addr_last) r_load_err <= 1'b1;
        end
        S_RUN: begin
          if (halt_i) begin
            r_ret      <= S_IDLE;
            r_widx     <= '0;
            r_byte_cnt <= '0;
          end
        end
        S_STEP: r_step_halt <= halt_i;
        S_STEP_POST: begin
          // A halt retiring on or right after the step ends stepping
          r_ret      <= (r_step_halt || halt_i) ? S_IDLE : S_STEP_WAIT;
          r_widx     <= '0;
          r_byte_cnt <= '0;
        end
        S_DUMP_ADDR: begin
          r_reg_addr <= w_reg_sel ? NB_REG'(r_widx - NB_WIDX'(2)) : '0;
`ifdef DEBUG_DMEM_DUMP_EN
          r_dmem_addr <= w_dmem_sel ? NB_ADDR'(r_widx - NB_WIDX'(2 + N_REGISTER)) : '0;
`endif
        end
        S_DUMP_CAP: r_shift <= w_word_src;
        S_DUMP_WAIT: begin
          if (tx_done_i) begin
            r_shift <= r_shift >> N_BITS;
            if (w_byte_last) begin
              r_byte_cnt <= '0;
              r_widx     <= r_widx + NB_WIDX'(1);
            end else begin
              r_byte_cnt <= r_byte_cnt + NB_BCNT'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_data_o     = r_shift[N_BITS-1:0];
  assign tx_start_o    = w_tx_start;
  assign imem_wr_en_o  = w_imem_wr;
  assign imem_addr_o   = r_addr;
  assign imem_data_o   = r_word;
  assign en_pipeline_o = w_en;
  assign reg_addr_o    = r_reg_addr;
  assign load_err_o    = r_load_err;
`ifdef DEBUG_DMEM_DUMP_EN
  assign dmem_addr_o   = r_dmem_addr;
`endif

endmodule

// File: doc/debug_controller.md
Name: debug_controller

Overview:
- Parametrised UART-side debug/control unit for the MIPS pipeline; supersedes the receive-only loader and the finish-triggered run enable.
- Assembles rx bytes into instruction words and writes them to instruction memory.
- Gates the pipeline in continuous or single-step mode and stops on halt.
- Serialises PC, cycle count and register file back over tx.

Parameters:
NB_DATA, 32, data/instruction word width
N_BYTES, 4, bytes per word (NB_DATA = N_BYTES*N_BITS)
N_BITS, 8, UART byte width
NB_ADDR, 7, instruction memory word-address width
NB_PC, 7, PC width
NB_REG, 5, register address width
N_REGISTER, 32, registers dumped
HALT_WORD, 32'hFFFF_FFFF, instruction word that ends a program load

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-high reset
rx_data_i  in  N_BITS  received byte
rx_done_i  in  1  one-cycle strobe, rx_data_i valid
tx_data_o  out  N_BITS  byte to transmit
tx_start_o  out  1  one-cycle transmit request
tx_done_i  in  1  one-cycle strobe, transmitter finished byte
imem_wr_en_o  out  1  instruction memory write strobe
imem_addr_o  out  NB_ADDR  instruction memory word address
imem_data_o  out  NB_DATA  instruction word
en_pipeline_o  out  1  pipeline advance enable
halt_i  in  1  halt instruction retired in WB
pc_i  in  NB_PC  current PC
reg_addr_o  out  NB_REG  register file debug read address
reg_data_i  in  NB_DATA  register data (combinational read)
load_err_o  out  1  sticky: load filled memory without HALT_WORD

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; byte/word/address/cycle counters 0.
- IDLE: act on rx_done_i only. Commands: 0x4C 'L' -> LOAD; 0x43 'C' -> RUN; 0x53 'S' -> STEP_WAIT. Other bytes are ignored.
- Entering RUN or STEP_WAIT clears the cycle counter and load_err_o is unaffected. Entering LOAD clears load_err_o and the write address.
- LOAD assembly: bytes assembled LSB-first; N_BYTES-th byte completes a word.
- LOAD write: the cycle after a word completes, imem_wr_en_o=1 for 1 cycle with the current address and word; the address then increments.
- LOAD exit: if the word == HALT_WORD, write it, then go to IDLE. If the write used address 2^NB_ADDR-1 and the word != HALT_WORD, go to IDLE and set load_err_o.
- RUN: en_pipeline_o=1 every cycle; cycle counter +1 per enabled cycle, wrapping modulo 2^NB_DATA. When halt_i=1, en_pipeline_o=0 from the next cycle, then go to DUMP with return state IDLE.
- STEP_WAIT: each 'N' (0x4E) strobe gives en_pipeline_o=1 for exactly 1 cycle (counted), then DUMP. Return state is STEP_WAIT, or IDLE if halt_i was seen during or immediately after the step cycle. 'Q' (0x51) -> IDLE. Other bytes are ignored.
- DUMP order, each word LSB byte first:
  - pc_i zero-extended to NB_DATA;
  - cycle counter;
  - registers 0..N_REGISTER-1, addressed via reg_addr_o.
- DUMP size: N_BYTES*(2+N_REGISTER) bytes, 136 at defaults.
- DUMP data capture: words are captured into a shift register at word start; register N is captured while reg_addr_o=N is held stable for at least 1 cycle.
- TX handshake: tx_start_o pulses 1 cycle with tx_data_o valid. tx_data_o is held until tx_done_i; the next tx_start_o comes no earlier than the cycle after tx_done_i.
- rx strobes during RUN and DUMP are ignored and not queued.
- en_pipeline_o is 0 in all states except the RUN and step cycles.
- Reset mid-LOAD or mid-DUMP aborts immediately. Partial word discarded, tx_start_o=0.

Optional Feature:
- Macro: DEBUG_DMEM_DUMP_EN.
- With the macro defined:
  - extra parameter N_DMEM_WORDS (default 32) and extra ports dmem_addr_o (out, NB_ADDR) and dmem_data_i (in, NB_DATA);
  - DUMP appends N_DMEM_WORDS data-memory words after the registers, LSB first, for N_BYTES*(2+N_REGISTER+N_DMEM_WORDS) bytes (264 at defaults).
- Without the macro: those ports and the parameter are absent, and the dump is 136 bytes.

Test Plan:
- Load: send 0x4C, then bytes 78 56 34 12 FF FF FF FF -> imem write addr0=0x12345678, addr1=0xFFFFFFFF; returns to IDLE; load_err_o=0.
- Load overflow at NB_ADDR=3: send 0x4C + 8 words of 0x00000001 -> writes to addr 0..7, IDLE after the 8th, load_err_o=1.
- Run: halt_i asserted after 5 enabled cycles, pc_i=0x14 -> en_pipeline_o high exactly 5 cycles; dump starts 14 00 00 00 05 00 00 00; 136 bytes total; ends in IDLE.
- Step: send 0x53, then 0x4E twice -> two single-cycle en_pipeline_o pulses; two 136-byte dumps with cycle fields 1 and 2. Then 0x51 -> IDLE.
- TX backpressure: delay tx_done_i 20 cycles per byte -> tx_data_o stable throughout, one tx_start_o per byte, no byte lost. rx 'C' during dump is ignored.
- Reset asserted mid-dump (byte 50) -> all outputs 0 same cycle; after release, IDLE accepts 0x4C.
